// File: rtl/mandel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mandel_pkg : shared constants and state encoding for the view mappers |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mandel_pkg;

  localparam int FP_W_DEF = 32;
  localparam int FRAC_DEF = 24;
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 600;
  localparam int QB_DEF   = 12;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIV_RE = 3'd1,
    ST_DIV_IM = 3'd2,
    ST_FIN    = 3'd3,
    ST_DONE   = 3'd4
  } loc_state_e;

endpackage
`default_nettype wire

// File: rtl/serial_udiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_udiv : unsigned restoring divider, one quotient bit per cycle  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module serial_udiv #(
  parameter int N_W = 33,
  parameter int D_W = 32,
  parameter int QB  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [QB-1:0]  quotient,
  output logic [N_W-1:0] remainder,
  output logic           ovf
);

  localparam int SW = D_W + QB;

  logic [N_W-1:0] r_rem;
  logic [SW-1:0]  r_dsh;
  logic [QB-1:0]  r_q;
  logic [3:0]     r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_ovf;

  logic [N_W-1:0] w_rem_src;
  logic [SW-1:0]  w_dsh_src;
  logic [N_W-1:0] w_rem_nxt;
  logic           w_ge;
  logic           w_ovf;

  // The start edge already performs the first iteration, so QB edges total.
  always_comb begin
    w_rem_src = start ? dividend : r_rem;
    w_dsh_src = start ? (SW'(divisor) << (QB - 1)) : r_dsh;
    w_ge      = SW'(w_rem_src) >= w_dsh_src;
    w_rem_nxt = w_ge ? (w_rem_src - w_dsh_src[N_W-1:0]) : w_rem_src;
    w_ovf     = SW'(dividend) >= {divisor, {QB{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dsh  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (start) begin
      r_rem  <= w_rem_nxt;
      r_dsh  <= w_dsh_src >> 1;
      r_q    <= {{(QB-1){1'b0}}, w_ge};
      r_cnt  <= 4'd1;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_ovf  <= w_ovf;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_dsh <= w_dsh_src >> 1;
      r_q   <= {r_q[QB-2:0], w_ge};
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'(QB - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_q;
  assign remainder = r_rem;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: rtl/pixel_locator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_locator : maps a fixed-point complex point back to a pixel      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pixel_locator
  import mandel_pkg::*;
#(
  parameter int FP_W = FP_W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int W    = SCREEN_W,
  parameter int H    = SCREEN_H,
  parameter int QB   = QB_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [FP_W-1:0] c_re,
  input  logic signed [FP_W-1:0] c_im,
  input  logic signed [FP_W-1:0] center_re,
  input  logic signed [FP_W-1:0] center_im,
  input  logic signed [FP_W-1:0] scale,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic                   in_range,
  output logic                   err_scale
);

  localparam int DW = FP_W + 1;
  localparam int PW = 14;

  if (FRAC >= FP_W || (1 << QB) <= ((W > H ? W : H) / 2) || QB > 15) begin : g_param_check
    $error("pixel_locator: inconsistent FRAC/QB parameters");
  end

  loc_state_e r_state, w_next;

  logic            r_neg_re;
  logic [DW-1:0]   r_dim;
  logic [FP_W-1:0] r_scale;
  logic            r_err;
  logic [QB-1:0]   r_q_re;
  logic            r_nz_re;
  logic            r_ovf_re;

  logic [DW-1:0]   w_dre, w_dim, w_div_a, w_div_rem;
  logic [FP_W-1:0] w_div_b;
  logic [QB-1:0]   w_div_q;
  logic            w_div_start, w_div_busy, w_div_done, w_div_ovf;
  logic [PW-1:0]   w_px, w_py;
  logic            w_x_clip, w_y_clip;
  logic [X_W-1:0]  w_x;
  logic [Y_W-1:0]  w_y;

  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] d);
    return d[DW-1] ? (~d + 1'b1) : d;
  endfunction

  // Floor toward -inf: a negative offset with a nonzero remainder steps one
  // more pixel down. Overflowed axes are pushed far enough to always clip.
  function automatic logic [PW-1:0] place(input logic neg, input logic ovf,
                                          input logic [QB-1:0] q, input logic nz,
                                          input int half);
    logic [PW-1:0] mag;
    mag = ovf ? PW'(1 << QB) : (PW'(q) + PW'(nz && neg));
    return PW'(half) + (neg ? (~mag + 1'b1) : mag);
  endfunction

  assign w_dre = {c_re[FP_W-1], c_re} - {center_re[FP_W-1], center_re};
  assign w_dim = {c_im[FP_W-1], c_im} - {center_im[FP_W-1], center_im};

  assign w_div_start = ((r_state == ST_IDLE) && in_valid) ||
                       ((r_state == ST_DIV_RE) && w_div_done);
  assign w_div_a     = (r_state == ST_IDLE) ? magnitude(w_dre) : magnitude(r_dim);
  assign w_div_b     = (r_state == ST_IDLE) ? scale : r_scale;

  serial_udiv #(
    .N_W (DW),
    .D_W (FP_W),
    .QB  (QB)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .dividend  (w_div_a),
    .divisor   (w_div_b),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_div_q),
    .remainder (w_div_rem),
    .ovf       (w_div_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_next = ST_DIV_RE;
      ST_DIV_RE: if (w_div_done && !w_div_busy) w_next = ST_DIV_IM;
      ST_DIV_IM: if (w_div_done && !w_div_busy) w_next = ST_FIN;
      ST_FIN:    w_next = ST_DONE;
      ST_DONE:   if (out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Imaginary-axis results are read live from the divider during FIN.
  always_comb begin
    w_px     = place(r_neg_re, r_ovf_re, r_q_re, r_nz_re, W / 2);
    w_py     = place(r_dim[DW-1], w_div_ovf, w_div_q, |w_div_rem, H / 2);
    w_x_clip = w_px[PW-1] || (w_px > PW'(W - 1));
    w_y_clip = w_py[PW-1] || (w_py > PW'(H - 1));
    w_x      = w_px[PW-1] ? '0 : (w_x_clip ? X_W'(W - 1) : w_px[X_W-1:0]);
    w_y      = w_py[PW-1] ? '0 : (w_y_clip ? Y_W'(H - 1) : w_py[Y_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_re  <= 1'b0;
      r_dim     <= '0;
      r_scale   <= '0;
      r_err     <= 1'b0;
      r_q_re    <= '0;
      r_nz_re   <= 1'b0;
      r_ovf_re  <= 1'b0;
      x         <= '0;
      y         <= '0;
      in_range  <= 1'b0;
      err_scale <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_neg_re <= w_dre[DW-1];
          r_dim    <= w_dim;
          r_scale  <= scale;
          r_err    <= (scale <= 0);
        end
        ST_DIV_RE: if (w_div_done) begin
          r_q_re   <= w_div_q;
          r_nz_re  <= |w_div_rem;
          r_ovf_re <= w_div_ovf;
        end
        ST_FIN: begin
          x         <= r_err ? '0 : w_x;
          y         <= r_err ? '0 : w_y;
          in_range  <= !r_err && !r_ovf_re && !w_div_ovf && !w_x_clip && !w_y_clip;
          err_scale <= r_err;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_locator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pixel_locator : directed and round-trip checks for pixel_locator   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pixel_locator;

  localparam int S = 1 << 14;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic signed [31:0] c_re, c_im, center_re, center_im, scale;
  logic [10:0]        x;
  logic [9:0]         y;
  logic               in_range, err_scale;

  int n_chk = 0;
  int n_err = 0;

  pixel_locator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_re      (c_re),
    .c_im      (c_im),
    .center_re (center_re),
    .center_im (center_im),
    .scale     (scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .in_range  (in_range),
    .err_scale (err_scale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Starts and ends just after a falling edge; lat counts edges from acceptance.
  task automatic do_req(input logic signed [31:0] cr, ci, zr, zi, sc, output int lat);
    int guard;
    c_re = cr; c_im = ci; center_re = zr; center_im = zi; scale = sc;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic locate(input string tag, input logic signed [31:0] cr, ci, zr, zi, sc,
                        input int ex, ey, er, ee);
    int lat;
    do_req(cr, ci, zr, zi, sc, lat);
    check({tag, "_lat"}, lat, 25);
    check({tag, "_x"}, x, ex);
    check({tag, "_y"}, y, ey);
    check({tag, "_in_range"}, in_range, er);
    check({tag, "_err"}, err_scale, ee);
    handshake();
  endtask

  initial begin
    int lat;
    logic stable, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    c_re = '0; c_im = '0; center_re = '0; center_im = '0; scale = S;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_in_range", in_range, 0);
    check("rst_err", err_scale, 0);
    rst_n = 1'b1;
    @(negedge clk);

    locate("origin",   0,        0,        0, 0, S, 512,  300, 1, 0);
    locate("floor",    100 * S,  -1,       0, 0, S, 612,  299, 1, 0);
    locate("clip_y",   0,        300 * S,  0, 0, S, 512,  599, 0, 0);
    locate("clip_x",   -600 * S, 0,        0, 0, S, 0,    300, 0, 0);
    locate("edge_hi",  511 * S,  299 * S,  0, 0, S, 1023, 599, 1, 0);
    locate("edge_lo",  -512 * S, -300 * S, 0, 0, S, 0,    0,   1, 0);
    locate("over_x",   512 * S,  0,        0, 0, S, 1023, 300, 0, 0);
    locate("ovf_pos",  32'sh7FFFFFFF, 0, 0, 0, S, 1023, 300, 0, 0);
    locate("ovf_wide", 32'sh80000000, 0, 32'sh7FFFFFFF, 0, S, 0, 300, 0, 0);
    locate("scale0",   5 * S,    5 * S,    0, 0, 0,  0, 0, 0, 1);
    locate("scale_n",  5 * S,    5 * S,    0, 0, -5, 0, 0, 0, 1);

    // Backpressure then back-to-back acceptance
    do_req(0, 0, 0, 0, S, lat);
    check("bp_lat", lat, 25);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (x !== 11'd512 || y !== 10'd300 || in_range !== 1'b1 || !out_valid || in_ready)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    handshake();
    check("bp_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    locate("b2b", 10 * S, -10 * S, 0, 0, S, 522, 290, 1, 0);

    // Reset while the real-axis division is in progress
    c_re = 7 * S; c_im = 0; center_re = 0; center_im = 0; scale = S;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", x, 0);
    check("mid_rst_in_range", in_range, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_valid", seen, 0);
    check("mid_rst_ready", in_ready, 1);

    // Round trip: pixel -> forward mapping (plus sub-pixel offset) -> locator
    for (int i = 0; i < 1000; i++) begin
      int px, py, sc, zr, zi, fr, fi;
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 599);
      sc = $urandom_range(1, 65536);
      zr = int'($urandom_range(0, 2097152)) - 1048576;
      zi = int'($urandom_range(0, 2097152)) - 1048576;
      fr = $urandom_range(0, sc - 1);
      fi = $urandom_range(0, sc - 1);
      locate("rt", zr + (px - 512) * sc + fr, zi + (py - 300) * sc + fi, zr, zi, sc,
             px, py, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_locator.md
# pixel_locator

Inverse of the pixel-to-complex mapping: converts a fixed-point complex point c back to the screen pixel (x,y) under the current view (center, scale). It computes `x = W/2 + floor((c_re-center_re)/scale)` and `y = H/2 + floor((c_im-center_im)/scale)` with one shared serial divider, using a valid/ready handshake on both sides. It serves the zoom and marker path, which places overlays such as a zoom target or an orbit point onto the framebuffer.

## Interface
- FP_W, 32: fixed-point word width, two's complement.
- FRAC, 24: fractional bits. Used for documentation only; the quotient is integer pixels, so FRAC cancels.
- W, 1024: screen width in pixels.
- H, 600: screen height in pixels.
- QB, 12: quotient magnitude bits, i.e. the number of divider iterations per axis. Must satisfy 2^QB > max(W,H)/2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- c_re, c_im  in  FP_W signed  point to locate.
- center_re, center_im  in  FP_W signed  view center.
- scale  in  FP_W signed  step per pixel; must be > 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- x  out  11  pixel column, 0..W-1 (clamped).
- y  out  10  pixel row, 0..H-1 (clamped).
- in_range  out  1  point lies on screen, unclamped.
- err_scale  out  1  scale <= 0 was presented.

## Operation
- States: IDLE, DIV_RE, DIV_IM, FIN, DONE.
- in_ready is a combinational decode of state==IDLE.
- Acceptance happens on a clock edge with in_valid && in_ready. On that edge the block:
  - registers dre = c_re-center_re and dim = c_im-center_im at FP_W+1 bits (no wrap);
  - registers scale;
  - registers err = (scale <= 0);
  - moves to DIV_RE.
- DIV_RE and DIV_IM each run exactly QB restoring-division iterations on |d| / scale. A 4-bit counter steps the iterations.
- Overflow: if |d| >= scale<<QB, the axis is flagged ovf. The iterations still run.
- Sign/floor rule:
  - q = trunc(|d|/scale);
  - if d < 0, then delta = -(q + (rem != 0));
  - otherwise delta = q.
  - Example: d = -1 LSB gives delta = -1.
- FIN registers the outputs:
  - p = W/2 + delta (respectively H/2 + delta), computed signed at 14 bits;
  - clamp p to [0, W-1] (respectively [0, H-1]);
  - in_range = !err && !ovf_re && !ovf_im && both unclamped;
  - if err, then x = y = 0 and in_range = 0;
  - err_scale = err.
- DONE holds out_valid and all outputs stable until out_ready is sampled high. Then go to IDLE.
- Exactly one request is in flight at a time. Inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, x=0, y=0, in_range=0, err_scale=0, divider registers 0.
- Let E0 be the acceptance edge:
  - E1..E(QB): DIV_RE;
  - E(QB+1)..E(2QB): DIV_IM;
  - E(2QB+1): FIN, with out_valid rising after this edge.
  - Latency is fixed at 2·QB+1 = 25 cycles for every input, including err and ovf.
- out_valid and out_ready both high on edge En: out_valid falls and in_ready rises after En. The earliest next acceptance is En+1.
  - Maximum throughput is one request per 2·QB+3 cycles.
- out_valid is never withdrawn before the handshake. Outputs do not change while out_valid=1.
- Reset mid-operation: asserting rst_n low at any time drops the in-flight request immediately and returns all outputs to reset values. No result is emitted after release.
- in_valid held high while busy: no effect. Acceptance occurs on the first IDLE edge.

## Structure
- Shared package `mandel_pkg`:
  - FP_W, FRAC, W, H defaults;
  - pixel-coordinate widths (11/10);
  - state encoding constants.
  - The forward mapper and this block share these.
- Sub-module `serial_udiv`:
  - unsigned restoring divider, one quotient bit per cycle;
  - start/busy/done signals;
  - outputs quotient, remainder, and ovf;
  - instantiated once and reused for both axes.
- The top level holds the FSM, the sign/floor correction, the offset add, and the clamping.

## Test plan
All scenarios use W=1024, H=600, FRAC=24, center=0, scale=2^14.
- c=(0,0) -> x=512, y=300, in_range=1, out_valid exactly 25 cycles after acceptance.
- c_re=100·2^14, c_im=-1 LSB -> x=612, y=299 (floor rule), in_range=1.
- c_im=300·2^14 -> y clamped to 599, in_range=0. c_re=-600·2^14 -> x=0, in_range=0.
- scale=0 and scale=-5 -> err_scale=1, x=y=0, in_range=0, latency still 25.
- Backpressure: hold out_ready low for 10 cycles -> outputs stable, in_ready=0 throughout. After the handshake, in_ready rises the next cycle and a back-to-back request is accepted.
- Reset pulse at cycle 7 of DIV_RE -> out_valid stays 0 and in_ready=1 after release. A random sweep of 1000 round-trip points (pixel -> forward mapping -> this block) must return the original pixel.
